// File: rtl/arbitro_escrita_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module : arbitro_escrita_regs_pkg
// Brief  : Shared FSM encoding and width helper for the register write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package arbitro_escrita_regs_pkg;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Ceiling log2, never below 1 so single-entry fields keep a usable width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_escrita_regs_rr_prio_sel.sv
`default_nettype none
// ============================================================================
// Module : arbitro_escrita_regs_rr_prio_sel
// Brief  : Combinational round-robin picker: first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
module arbitro_escrita_regs_rr_prio_sel
    import arbitro_escrita_regs_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   index,
    output logic               any
);

    localparam logic [PTR_W:0] c_num_req = (PTR_W + 1)'(NUM_REQ);

    logic [PTR_W:0] w_dist;
    logic [PTR_W:0] w_best;

    // Winner is the requester with the smallest modular distance from ptr.
    always_comb begin
        gnt    = '0;
        index  = '0;
        any    = 1'b0;
        w_dist = '0;
        w_best = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) >= ptr) begin
                w_dist = (PTR_W + 1)'(i) - {1'b0, ptr};
            end else begin
                w_dist = (PTR_W + 1)'(i) + c_num_req - {1'b0, ptr};
            end
            if (req[i] && (!any || (w_dist < w_best))) begin
                w_best = w_dist;
                index  = PTR_W'(i);
                any    = 1'b1;
            end
        end
        if (any) begin
            gnt[index] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbitro_escrita_regs.sv
`default_nettype none
// ============================================================================
// Module : arbitro_escrita_regs
// Brief  : Round-robin write arbiter with locked bursts for a register bank.
// Rev    : 1.0  initial release
// ============================================================================
module arbitro_escrita_regs
    import arbitro_escrita_regs_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_REG   = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    localparam int ADDR_W   = clog2(NUM_REG)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REG-1:0]         load,
    output logic [DATA_W-1:0]          valor,
    output logic                       busy,
    output logic                       err_addr
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0]  c_burst_max = CNT_W'(MAX_BURST);
    localparam logic              c_burst_en  = (MAX_BURST > 1);
    localparam logic [ADDR_W:0]   c_num_reg   = (ADDR_W + 1)'(NUM_REG);
    localparam logic [PTR_W-1:0]  c_last_req  = PTR_W'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [NUM_REG-1:0] r_load;
    logic [DATA_W-1:0]  r_valor;
    logic               r_err_addr;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_xfer;
    logic               w_enter_lock;
    logic [CNT_W-1:0]   w_burst_next;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_data;
    logic [NUM_REG-1:0] w_dec;
    logic               w_addr_bad;

    logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  w_data_arr [NUM_REQ];

    arbitro_escrita_regs_rr_prio_sel #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_prio_sel (
        .req   (req),
        .ptr   (r_rr_ptr),
        .gnt   (w_pick_gnt),
        .index (w_pick_idx),
        .any   (w_pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // While locked the owner is the only candidate, so its slot drives the write path.
    assign w_win_idx    = (r_state == ST_LOCKED) ? r_owner : w_pick_idx;
    assign w_win_addr   = w_addr_arr[w_win_idx];
    assign w_win_data   = w_data_arr[w_win_idx];
    assign w_xfer       = |(gnt & req);
    assign w_enter_lock = (r_state == ST_ARB) && w_pick_any &&
                          req_lock[w_pick_idx] && c_burst_en;
    assign w_burst_next = r_burst_cnt + CNT_W'(1);
    assign w_addr_bad   = ({1'b0, w_win_addr} >= c_num_reg);

    // Out-of-range addresses match no decoder output, leaving load all-zero.
    generate
        for (gi = 0; gi < NUM_REG; gi++) begin : g_dec
            assign w_dec[gi] = (w_win_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_enter_lock) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!req[r_owner]) begin
                    w_state_next = ST_ARB;
                end else if (!req_lock[r_owner] || (w_burst_next >= c_burst_max)) begin
                    w_state_next = ST_ARB;
                end
            end
            default: w_state_next = ST_ARB;
        endcase
    end

    always_comb begin
        gnt  = '0;
        busy = (r_state == ST_LOCKED);
        if (!reset) begin
            if (r_state == ST_ARB) begin
                gnt = w_pick_gnt;
            end else begin
                gnt[r_owner] = req[r_owner];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr <= (w_win_idx == c_last_req) ? '0 : w_win_idx + PTR_W'(1);
            end
            if (w_enter_lock) begin
                r_owner     <= w_pick_idx;
                r_burst_cnt <= CNT_W'(1);
            end else if ((r_state == ST_LOCKED) && w_xfer) begin
                r_burst_cnt <= w_burst_next;
            end else if (r_state == ST_ARB) begin
                r_burst_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_load     <= '0;
            r_valor    <= '0;
            r_err_addr <= 1'b0;
        end else begin
            r_load     <= w_xfer ? w_dec : '0;
            r_err_addr <= w_xfer & w_addr_bad;
            if (w_xfer) begin
                r_valor <= w_win_data;
            end
        end
    end

    assign load     = r_load;
    assign valor    = r_valor;
    assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_escrita_regs.sv
`default_nettype none
// ============================================================================
// Module : tb_arbitro_escrita_regs
// Brief  : Directed vector bench for the register write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_arbitro_escrita_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req, req_lock, gnt;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  load;
    logic [15:0] valor;
    logic        busy, err_addr;

    logic [3:0]  req6, lock6, gnt6;
    logic [11:0] addr6;
    logic [63:0] data6;
    logic [5:0]  load6;
    logic [15:0] valor6;
    logic        busy6, err6;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    arbitro_escrita_regs #(
        .NUM_REQ(4), .NUM_REG(8), .DATA_W(16), .MAX_BURST(4)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .load(load),
        .valor(valor), .busy(busy), .err_addr(err_addr)
    );

    arbitro_escrita_regs #(
        .NUM_REQ(4), .NUM_REG(6), .DATA_W(16), .MAX_BURST(4)
    ) dut6 (
        .clock(clock), .reset(reset), .req(req6), .req_lock(lock6),
        .req_addr(addr6), .req_data(data6), .gnt(gnt6), .load(load6),
        .valor(valor6), .busy(busy6), .err_addr(err6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  gnt;
        logic [7:0]  load;
        logic [15:0] valor;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl [30];

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // addr: r0=7 r1=1 r2=5 r3=3 ; data: r0=1000 r1=1111 r2=ABCD r3=3333
        //          req    lock   gnt    load          valor     busy err
        tbl[ 0] = '{4'h0, 4'h0, 4'h0, 8'b0000_0000, 16'h0000, 1'b0, 1'b0};
        tbl[ 1] = '{4'h0, 4'h0, 4'h0, 8'b0000_0000, 16'h0000, 1'b0, 1'b0};
        tbl[ 2] = '{4'h0, 4'h0, 4'h0, 8'b0000_0000, 16'h0000, 1'b0, 1'b0};
        tbl[ 3] = '{4'h4, 4'h0, 4'h4, 8'b0000_0000, 16'h0000, 1'b0, 1'b0};
        tbl[ 4] = '{4'h0, 4'h0, 4'h0, 8'b0010_0000, 16'hABCD, 1'b0, 1'b0};
        tbl[ 5] = '{4'h8, 4'h0, 4'h8, 8'b0000_0000, 16'hABCD, 1'b0, 1'b0};
        tbl[ 6] = '{4'hF, 4'h0, 4'h1, 8'b0000_1000, 16'h3333, 1'b0, 1'b0};
        tbl[ 7] = '{4'hF, 4'h0, 4'h2, 8'b1000_0000, 16'h1000, 1'b0, 1'b0};
        tbl[ 8] = '{4'hF, 4'h0, 4'h4, 8'b0000_0010, 16'h1111, 1'b0, 1'b0};
        tbl[ 9] = '{4'hF, 4'h0, 4'h8, 8'b0010_0000, 16'hABCD, 1'b0, 1'b0};
        tbl[10] = '{4'hF, 4'h0, 4'h1, 8'b0000_1000, 16'h3333, 1'b0, 1'b0};
        tbl[11] = '{4'hF, 4'h0, 4'h2, 8'b1000_0000, 16'h1000, 1'b0, 1'b0};
        tbl[12] = '{4'hF, 4'h0, 4'h4, 8'b0000_0010, 16'h1111, 1'b0, 1'b0};
        tbl[13] = '{4'hF, 4'h0, 4'h8, 8'b0010_0000, 16'hABCD, 1'b0, 1'b0};
        tbl[14] = '{4'h0, 4'h0, 4'h0, 8'b0000_1000, 16'h3333, 1'b0, 1'b0};
        tbl[15] = '{4'hE, 4'h2, 4'h2, 8'b0000_0000, 16'h3333, 1'b0, 1'b0};
        tbl[16] = '{4'hE, 4'h2, 4'h2, 8'b0000_0010, 16'h1111, 1'b1, 1'b0};
        tbl[17] = '{4'hE, 4'h2, 4'h2, 8'b0000_0010, 16'h1111, 1'b1, 1'b0};
        tbl[18] = '{4'hE, 4'h2, 4'h2, 8'b0000_0010, 16'h1111, 1'b1, 1'b0};
        tbl[19] = '{4'hE, 4'h2, 4'h4, 8'b0000_0010, 16'h1111, 1'b0, 1'b0};
        tbl[20] = '{4'hE, 4'h2, 4'h8, 8'b0010_0000, 16'hABCD, 1'b0, 1'b0};
        tbl[21] = '{4'h0, 4'h0, 4'h0, 8'b0000_1000, 16'h3333, 1'b0, 1'b0};
        tbl[22] = '{4'h0, 4'h0, 4'h0, 8'b0000_0000, 16'h3333, 1'b0, 1'b0};
        tbl[23] = '{4'h1, 4'h1, 4'h1, 8'b0000_0000, 16'h3333, 1'b0, 1'b0};
        tbl[24] = '{4'h1, 4'h0, 4'h1, 8'b1000_0000, 16'h1000, 1'b1, 1'b0};
        tbl[25] = '{4'h3, 4'h0, 4'h2, 8'b1000_0000, 16'h1000, 1'b0, 1'b0};
        tbl[26] = '{4'h4, 4'h4, 4'h4, 8'b0000_0010, 16'h1111, 1'b0, 1'b0};
        tbl[27] = '{4'h8, 4'h0, 4'h0, 8'b0010_0000, 16'hABCD, 1'b1, 1'b0};
        tbl[28] = '{4'h8, 4'h0, 4'h8, 8'b0000_0000, 16'hABCD, 1'b0, 1'b0};
        tbl[29] = '{4'h0, 4'h0, 4'h0, 8'b0000_1000, 16'h3333, 1'b0, 1'b0};

        reset    = 1'b1;
        req      = '0;
        req_lock = '0;
        req_addr = {3'd3, 3'd5, 3'd1, 3'd7};
        req_data = {16'h3333, 16'hABCD, 16'h1111, 16'h1000};
        req6     = '0;
        lock6    = '0;
        addr6    = '0;
        data6    = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            req      = tbl[i].req;
            req_lock = tbl[i].lock;
            @(negedge clock);
            chk($sformatf("gnt[%0d]", i),   32'(gnt),      32'(tbl[i].gnt));
            chk($sformatf("load[%0d]", i),  32'(load),     32'(tbl[i].load));
            chk($sformatf("valor[%0d]", i), 32'(valor),    32'(tbl[i].valor));
            chk($sformatf("busy[%0d]", i),  32'(busy),     32'(tbl[i].busy));
            chk($sformatf("err[%0d]", i),   32'(err_addr), 32'(tbl[i].err));
            @(posedge clock);
            #1;
        end

        // Reset right after a transfer discards it and restarts the pointer.
        req_data[32 +: 16] = 16'h1234;
        req = 4'b0100;
        @(negedge clock);
        chk("rst_pre_gnt", 32'(gnt), 32'h4);
        @(posedge clock);
        #1 reset = 1'b1;
        req = 4'b1111;
        @(negedge clock);
        chk("rst_gnt_during", 32'(gnt), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        req = 4'b0000;
        @(negedge clock);
        chk("rst_load", 32'(load), 32'h0);
        chk("rst_valor", 32'(valor), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err_addr), 32'h0);
        @(posedge clock);
        #1 req = 4'b1111;
        @(negedge clock);
        chk("rst_ptr_gnt", 32'(gnt), 32'h1);
        @(posedge clock);
        #1 req = 4'b0000;
        @(negedge clock);
        chk("post_rst_load", 32'(load), 32'h80);
        chk("post_rst_valor", 32'(valor), 32'h1000);

        // NUM_REG=6 variant: address 6 is out of range, address 5 is the last valid one.
        addr6 = {3'd0, 3'd0, 3'd0, 3'd6};
        data6 = {48'h0, 16'hBEEF};
        @(posedge clock);
        #1 req6 = 4'b0001;
        @(negedge clock);
        chk("oor_gnt", 32'(gnt6), 32'h1);
        @(posedge clock);
        #1 req6 = 4'b0000;
        @(negedge clock);
        chk("oor_load", 32'(load6), 32'h0);
        chk("oor_err", 32'(err6), 32'h1);
        @(posedge clock);
        #1 addr6 = {3'd0, 3'd0, 3'd0, 3'd5};
        data6 = {48'h0, 16'h5555};
        req6 = 4'b0001;
        @(negedge clock);
        chk("oor_err_pulse", 32'(err6), 32'h0);
        @(posedge clock);
        #1 req6 = 4'b0000;
        @(negedge clock);
        chk("a5_load", 32'(load6), 32'h20);
        chk("a5_valor", 32'(valor6), 32'h5555);
        chk("a5_err", 32'(err6), 32'h0);
        chk("a5_busy", 32'(busy6), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
